// File: rtl/pattern_sequencer.sv
// Multi-track step sequencer: per-track pattern store plus a run/pause/restart
// step engine that emits gate levels, trigger pulses and a bar marker.
module pattern_sequencer #(
  parameter int SEL_W         = 2,
  parameter int STEPS         = 16,
  parameter int CLKS_PER_STEP = 6250000,
  parameter int STEP_W        = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [STEPS-1:0]             pattern,
  input  logic [SEL_W-1:0]             select,
  input  logic                         load,
  input  logic                         clear,
  input  logic                         run,
  input  logic                         restart,
  output logic [(2**SEL_W)-1:0]        gate,
  output logic [(2**SEL_W)-1:0]        trig,
  output logic                         bar,
  output logic [STEP_W-1:0]            step_pos,
  output logic                         running,
  output logic [(2**SEL_W)*STEPS-1:0]  patterns
);

  localparam int NT    = 2**SEL_W;
  localparam int DIV_W = $clog2(CLKS_PER_STEP);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLKS_PER_STEP - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED
  } state_t;

  state_t              r_state;
  logic [DIV_W-1:0]    r_div;
  logic [STEP_W-1:0]   r_step;
  logic [STEPS-1:0]    r_pat [NT];
  logic                r_load_q;
  logic [NT-1:0]       r_gate;
  logic [NT-1:0]       r_trig;
  logic                r_bar;

  state_t              w_state_nx;
  logic [DIV_W-1:0]    w_div_nx;
  logic [STEP_W-1:0]   w_step_nx;
  logic                w_bnd;
  logic [NT-1:0]       w_col;
  logic                w_wr;

  assign w_wr = load & ~r_load_q;

  always_comb begin
    w_state_nx = r_state;
    w_step_nx  = r_step;
    w_div_nx   = r_div;
    w_bnd      = 1'b0;
    if (restart) begin
      w_step_nx = '0;
      w_div_nx  = '0;
      if (run) begin
        w_state_nx = S_RUN;
        w_bnd      = 1'b1;
      end else begin
        w_state_nx = S_IDLE;
      end
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_step_nx = '0;
          w_div_nx  = '0;
          if (run) begin
            w_state_nx = S_RUN;
            w_bnd      = 1'b1;
          end
        end
        S_RUN: begin
          if (!run) begin
            w_state_nx = S_PAUSED;
            w_div_nx   = '0;
          end else if (r_div == DIV_LAST) begin
            w_div_nx  = '0;
            w_bnd     = 1'b1;
            w_step_nx = (r_step == STEP_LAST) ? '0 : r_step + 1'b1;
          end else begin
            w_div_nx = r_div + 1'b1;
          end
        end
        S_PAUSED: begin
          w_div_nx = '0;
          if (run) begin
            w_state_nx = S_RUN;
            w_bnd      = 1'b1;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // Boundary column reads the pre-edge store, so a same-edge clear or
  // write only shows up from the following boundary.
  for (genvar g = 0; g < NT; g++) begin : g_trk
    assign w_col[g] = r_pat[g][w_step_nx];
    assign patterns[g*STEPS +: STEPS] = r_pat[g];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_step  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_div   <= w_div_nx;
      r_step  <= w_step_nx;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_gate <= '0;
      r_trig <= '0;
      r_bar  <= 1'b0;
    end else if (w_bnd) begin
      r_gate <= w_col;
      r_trig <= w_col;
      r_bar  <= (w_step_nx == '0);
    end else begin
      r_trig <= '0;
      r_bar  <= 1'b0;
      if (w_state_nx != S_RUN) r_gate <= '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_load_q <= 1'b0;
      for (int t = 0; t < NT; t++) r_pat[t] <= '0;
    end else begin
      r_load_q <= load;
      if (clear) begin
        for (int t = 0; t < NT; t++) r_pat[t] <= '0;
      end else if (w_wr) begin
        r_pat[select] <= pattern;
      end
    end
  end

  assign gate     = r_gate;
  assign trig     = r_trig;
  assign bar      = r_bar;
  assign step_pos = r_step;
  assign running  = (r_state == S_RUN);

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer: 4 tracks, 8 steps, 4 clocks/step.
module tb_pattern_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [7:0]  pattern = '0;
  logic [1:0]  select = '0;
  logic        load = 1'b0;
  logic        clear = 1'b0;
  logic        run = 1'b0;
  logic        restart = 1'b0;
  logic [3:0]  gate;
  logic [3:0]  trig;
  logic        bar;
  logic [2:0]  step_pos;
  logic        running;
  logic [31:0] patterns;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] p0 = '0;
  logic [7:0] p1 = '0;

  pattern_sequencer #(
    .SEL_W(2), .STEPS(8), .CLKS_PER_STEP(4), .STEP_W(3)
  ) dut (
    .clk(clk), .resetn(resetn), .pattern(pattern), .select(select),
    .load(load), .clear(clear), .run(run), .restart(restart),
    .gate(gate), .trig(trig), .bar(bar), .step_pos(step_pos),
    .running(running), .patterns(patterns)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] col(input int s);
    return {2'b00, p1[s], p0[s]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 resetn = 1'b0;
    #1;
    n_vec++;
    if ({gate, trig, bar, step_pos, running} !== 13'd0 || patterns !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got g=%b t=%b b=%b s=%0d r=%b p=%h, need all 0",
               gate, trig, bar, step_pos, running, patterns);
    end
    tick();
    tick();
    resetn = 1'b1;
    tick();
    n_vec++;
    if ({gate, running, step_pos} !== 8'd0) begin
      n_err++;
      $display("FAIL reset_idle: got g=%b r=%b s=%0d, need 0", gate, running, step_pos);
    end
  endtask

  task automatic test_load();
    pattern = 8'h05; select = 2'd0; load = 1'b1;
    tick();
    load = 1'b0;
    p0 = 8'h05;
    n_vec++;
    if (patterns[7:0] !== 8'h05) begin
      n_err++;
      $display("FAIL load_pat0: got %h need 05", patterns[7:0]);
    end
    tick();
    pattern = 8'h80; select = 2'd1; load = 1'b1;
    tick();
    p1 = 8'h80;
    n_vec++;
    if (patterns[15:8] !== 8'h80) begin
      n_err++;
      $display("FAIL load_pat1: got %h need 80", patterns[15:8]);
    end
    select = 2'd2; pattern = 8'hFF;
    for (int i = 0; i < 10; i++) tick();
    n_vec++;
    if (patterns !== 32'h0000_8005) begin
      n_err++;
      $display("FAIL load_held: got %h need 00008005", patterns);
    end
    load = 1'b0;
    tick();
  endtask

  task automatic test_run();
    run = 1'b1;
    tick();
    n_vec++;
    if (trig !== 4'b0001 || bar !== 1'b1 || step_pos !== 3'd0 ||
        gate !== 4'b0001 || running !== 1'b1) begin
      n_err++;
      $display("FAIL run_first: got t=%b b=%b s=%0d g=%b r=%b need 0001 1 0 0001 1",
               trig, bar, step_pos, gate, running);
    end
    for (int k = 1; k <= 32; k++) begin
      int s;
      logic bnd;
      logic [3:0] et;
      tick();
      s   = (k / 4) % 8;
      bnd = (k % 4 == 0);
      et  = bnd ? col(s) : 4'b0000;
      n_vec++;
      if (step_pos !== 3'(s) || gate !== col(s) || trig !== et ||
          bar !== (bnd && s == 0) || running !== 1'b1) begin
        n_err++;
        $display("FAIL run_seq k=%0d: got s=%0d g=%b t=%b b=%b need s=%0d g=%b t=%b b=%b",
                 k, step_pos, gate, trig, bar, s, col(s), et, bnd && s == 0);
      end
    end
  endtask

  task automatic test_pause();
    for (int i = 0; i < 12; i++) tick();
    n_vec++;
    if (step_pos !== 3'd3) begin
      n_err++;
      $display("FAIL pause_pre: got s=%0d need 3", step_pos);
    end
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if (running !== 1'b0 || gate !== 4'd0 || trig !== 4'd0 || step_pos !== 3'd3) begin
        n_err++;
        $display("FAIL paused i=%0d: got r=%b g=%b t=%b s=%0d need 0 0 0 3",
                 i, running, gate, trig, step_pos);
      end
    end
    run = 1'b1;
    tick();
    n_vec++;
    if (running !== 1'b1 || step_pos !== 3'd3 || bar !== 1'b0) begin
      n_err++;
      $display("FAIL resume: got r=%b s=%0d b=%b need 1 3 0", running, step_pos, bar);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_vec++;
      if (step_pos !== ((i == 4) ? 3'd4 : 3'd3)) begin
        n_err++;
        $display("FAIL resume_step i=%0d: got s=%0d", i, step_pos);
      end
    end
  endtask

  task automatic test_midstep_write();
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 12) begin
        n_vec++;
        if (trig !== 4'b0010 || step_pos !== 3'd7) begin
          n_err++;
          $display("FAIL step7_trig: got t=%b s=%0d need 0010 7", trig, step_pos);
        end
      end
    end
    n_vec++;
    if (step_pos !== 3'd1 || gate !== 4'd0) begin
      n_err++;
      $display("FAIL step1: got s=%0d g=%b need 1 0000", step_pos, gate);
    end
    pattern = 8'hFF; select = 2'd0; load = 1'b1;
    tick();
    load = 1'b0;
    p0 = 8'hFF;
    n_vec++;
    if (patterns[7:0] !== 8'hFF) begin
      n_err++;
      $display("FAIL midwrite_store: got %h need ff", patterns[7:0]);
    end
    for (int i = 2; i <= 4; i++) begin
      tick();
      if (i < 4) begin
        n_vec++;
        if (gate[0] !== 1'b0 || step_pos !== 3'd1) begin
          n_err++;
          $display("FAIL midwrite_hold i=%0d: got g0=%b s=%0d need 0 1", i, gate[0], step_pos);
        end
      end
    end
    n_vec++;
    if (gate !== 4'b0001 || trig !== 4'b0001 || step_pos !== 3'd2) begin
      n_err++;
      $display("FAIL midwrite_apply: got g=%b t=%b s=%0d need 0001 0001 2",
               gate, trig, step_pos);
    end
  endtask

  task automatic test_clear();
    clear = 1'b1; load = 1'b1; pattern = 8'hAA; select = 2'd3;
    tick();
    clear = 1'b0; load = 1'b0;
    p0 = '0; p1 = '0;
    n_vec++;
    if (patterns !== 32'd0) begin
      n_err++;
      $display("FAIL clear_store: got %h need 0", patterns);
    end
    for (int i = 2; i <= 8; i++) begin
      tick();
      n_vec++;
      if (trig !== 4'd0 || (i >= 4 && gate !== 4'd0)) begin
        n_err++;
        $display("FAIL clear_notrig i=%0d: got t=%b g=%b need 0", i, trig, gate);
      end
    end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n_vec++;
    if (step_pos !== 3'd0 || bar !== 1'b1 || running !== 1'b1 || trig !== 4'd0) begin
      n_err++;
      $display("FAIL restart_run: got s=%0d b=%b r=%b t=%b need 0 1 1 0000",
               step_pos, bar, running, trig);
    end
    tick();
    tick();
    run = 1'b0; restart = 1'b1;
    tick();
    restart = 1'b0;
    n_vec++;
    if (step_pos !== 3'd0 || running !== 1'b0 || gate !== 4'd0 || bar !== 1'b0) begin
      n_err++;
      $display("FAIL restart_idle: got s=%0d r=%b g=%b b=%b need 0 0 0 0",
               step_pos, running, gate, bar);
    end
  endtask

  task automatic test_reset_midstep();
    pattern = 8'h05; select = 2'd0; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    run = 1'b1;
    tick();
    n_vec++;
    if (gate !== 4'b0001 || running !== 1'b1) begin
      n_err++;
      $display("FAIL prereset_gate: got g=%b r=%b need 0001 1", gate, running);
    end
    tick();
    resetn = 1'b0;
    #2;
    n_vec++;
    if ({gate, trig, bar, step_pos, running} !== 13'd0 || patterns !== 32'd0) begin
      n_err++;
      $display("FAIL async_reset: got g=%b t=%b b=%b s=%0d r=%b p=%h need all 0",
               gate, trig, bar, step_pos, running, patterns);
    end
    tick();
    n_vec++;
    if ({gate, trig, bar, running} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_hold: got g=%b t=%b b=%b r=%b need 0", gate, trig, bar, running);
    end
    resetn = 1'b1;
    tick();
    n_vec++;
    if (bar !== 1'b1 || running !== 1'b1 || step_pos !== 3'd0 || gate !== 4'd0) begin
      n_err++;
      $display("FAIL post_reset_run: got b=%b r=%b s=%0d g=%b need 1 1 0 0000",
               bar, running, step_pos, gate);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_run();
    test_pause();
    test_midstep_write();
    test_clear();
    test_reset_midstep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
